// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO switch debouncer: per-bit FSM states and default sizing.
package gpio_pkg;

  localparam int unsigned GPIO_WIDTH_DEF      = 8;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } db_state_t;

  // Counter width for a given stability window; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One switch bit: two-flop synchronizer, STABLE/COUNTING FSM and stability counter.
module debounce_bit
  import gpio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic level,
  output logic toggle
);

  localparam int unsigned      CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]    TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  db_state_t     state;
  logic [CW-1:0] cnt;
  logic          mismatch;
  logic          at_term;

  assign mismatch = sync[1] ^ level;
  assign at_term  = (cnt == TERM);
  // The count never reaches DEBOUNCE_CYCLES itself: the cycle that would is the toggle cycle.
  assign toggle   = (state == COUNTING) && mismatch && at_term;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync  <= '0;
      state <= STABLE;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], sw};
      case (state)
        STABLE: begin
          if (mismatch) begin
            state <= COUNTING;
            cnt   <= CW'(1);
          end
        end
        COUNTING: begin
          if (!mismatch) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (at_term) begin
            level <= ~level;
            state <= STABLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/gpio_debounce.sv
// Debounced switch bank with sticky change flag and optional per-bit edge pending masks.
// Define GPIO_EDGE_PEND_EN to build the rise/fall pending flops; otherwise those ports read 0.
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH           = GPIO_WIDTH_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_i,
  input  logic             ack_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic             changed_o,
  output logic [WIDTH-1:0] rise_pend_o,
  output logic [WIDTH-1:0] fall_pend_o
);

  if (DEBOUNCE_CYCLES < 2) begin : g_cycles_check
    $error("gpio_debounce: DEBOUNCE_CYCLES must be at least 2");
  end

  logic [WIDTH-1:0] toggle;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk   (clk),
      .reset (reset),
      .sw    (sw_i[i]),
      .level (gpio_o[i]),
      .toggle(toggle[i])
    );
  end

  // A new toggle wins over a simultaneous acknowledge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      changed_o <= 1'b0;
    end else begin
      changed_o <= (changed_o & ~ack_i) | (|toggle);
    end
  end

`ifdef GPIO_EDGE_PEND_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rise_pend_o <= '0;
      fall_pend_o <= '0;
    end else begin
      rise_pend_o <= (ack_i ? '0 : rise_pend_o) | (toggle & ~gpio_o);
      fall_pend_o <= (ack_i ? '0 : fall_pend_o) | (toggle &  gpio_o);
    end
  end
`else
  assign rise_pend_o = '0;
  assign fall_pend_o = '0;
`endif

endmodule

// File: tb/tb_gpio_debounce.sv
// Scoreboard bench for gpio_debounce (WIDTH=8, DEBOUNCE_CYCLES=4) with a sample-window reference model.
module tb_gpio_debounce;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         ack_i;
  logic [W-1:0] sw_i;
  logic [W-1:0] gpio_o;
  logic         changed_o;
  logic [W-1:0] rise_pend_o;
  logic [W-1:0] fall_pend_o;

  always #5 clk = ~clk;

  gpio_debounce #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_i       (sw_i),
    .ack_i      (ack_i),
    .gpio_o     (gpio_o),
    .changed_o  (changed_o),
    .rise_pend_o(rise_pend_o),
    .fall_pend_o(fall_pend_o)
  );

  typedef struct packed {
    logic [W-1:0] gpio;
    logic         changed;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Model: raw samples taken at each edge; an output bit flips when the D samples
  // that have cleared the two-stage synchronizer all disagree with it.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_out;
  logic         m_changed;
  logic [W-1:0] m_rise;
  logic [W-1:0] m_fall;

  function automatic void model_reset();
    hist.delete();
    repeat (D + 2) hist.push_back('0);
    m_out     = '0;
    m_changed = 1'b0;
    m_rise    = '0;
    m_fall    = '0;
  endfunction

  function automatic void model_step(input logic [W-1:0] sw, input logic ack);
    logic [W-1:0] tog;
    hist.push_back(sw);
    void'(hist.pop_front());
    for (int b = 0; b < W; b++) begin
      bit all_differ = 1'b1;
      for (int j = 0; j < D; j++)
        if (hist[j][b] == m_out[b]) all_differ = 1'b0;
      tog[b] = all_differ;
    end
    m_changed = (ack ? 1'b0 : m_changed) | (|tog);
`ifdef GPIO_EDGE_PEND_EN
    m_rise = (ack ? '0 : m_rise) | (tog & ~m_out);
    m_fall = (ack ? '0 : m_fall) | (tog &  m_out);
`endif
    m_out = m_out ^ tog;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic [W-1:0] sw, input logic ack, input logic rst);
    exp_t e;
    @(negedge clk);
    sw_i  = sw;
    ack_i = ack;
    reset = rst;
    @(posedge clk);
    if (!rst) model_reset();
    else model_step(sw, ack);
    e.gpio    = m_out;
    e.changed = m_changed;
    e.rise    = m_rise;
    e.fall    = m_fall;
    q.push_back(e);
  endtask

  // Monitor: every cycle presents a full output word; compare it with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_gpio",    32'(gpio_o),      32'(e.gpio));
        chk("sb_changed", 32'(changed_o),   32'(e.changed));
        chk("sb_rise",    32'(rise_pend_o), 32'(e.rise));
        chk("sb_fall",    32'(fall_pend_o), 32'(e.fall));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "time limit reached");
  end

  initial begin
    logic [W-1:0] cur;
    reset = 1'b0;
    sw_i  = '0;
    ack_i = 1'b0;
    model_reset();

    // Held-high switches during reset, then release.
    repeat (3) cycle(8'hFF, 1'b0, 1'b0);
    #3 chk("rst_gpio", 32'(gpio_o), 32'h00);
    for (int n = 1; n <= 8; n++) begin
      cycle(8'hFF, 1'b0, 1'b1);
      #3;
      if (n == 5) chk("rel_edge5_gpio", 32'(gpio_o), 32'h00);
      if (n == 6) begin
        chk("rel_edge6_gpio", 32'(gpio_o), 32'hFF);
        chk("rel_edge6_changed", 32'(changed_o), 32'h1);
      end
    end
    repeat (8) cycle(8'h00, 1'b0, 1'b1);
    cycle(8'h00, 1'b1, 1'b1);
    cycle(8'h00, 1'b0, 1'b1);

    // Short glitch on bit 0 is rejected.
    repeat (3) cycle(8'h01, 1'b0, 1'b1);
    repeat (8) cycle(8'h00, 1'b0, 1'b1);
    #3;
    chk("glitch_gpio", 32'(gpio_o), 32'h00);
    chk("glitch_changed", 32'(changed_o), 32'h0);

    // Two bits rise together, then acknowledge.
    for (int n = 1; n <= 8; n++) begin
      cycle(8'h81, 1'b0, 1'b1);
      #3;
      if (n == 6) begin
        chk("rise81_gpio", 32'(gpio_o), 32'h81);
`ifdef GPIO_EDGE_PEND_EN
        chk("rise81_rise", 32'(rise_pend_o), 32'h81);
        chk("rise81_fall", 32'(fall_pend_o), 32'h00);
`endif
      end
    end
    cycle(8'h81, 1'b1, 1'b1);
    #3;
    chk("ack_changed", 32'(changed_o), 32'h0);
    chk("ack_rise", 32'(rise_pend_o), 32'h00);
    chk("ack_fall", 32'(fall_pend_o), 32'h00);

    // Acknowledge on the same edge bit 3 toggles: the new event stays flagged.
    for (int n = 1; n <= 8; n++) begin
      cycle(8'h89, (n == 6), 1'b1);
      #3;
      if (n == 6) begin
        chk("ackset_gpio", 32'(gpio_o), 32'h89);
        chk("ackset_changed", 32'(changed_o), 32'h1);
      end
    end
    cycle(8'h89, 1'b1, 1'b1);

    // Reset mid-count discards progress.
    repeat (8) cycle(8'h00, 1'b0, 1'b1);
    cycle(8'h00, 1'b1, 1'b1);
    repeat (4) cycle(8'h01, 1'b0, 1'b1);
    repeat (2) cycle(8'h01, 1'b0, 1'b0);
    for (int n = 1; n <= 8; n++) begin
      cycle(8'h01, 1'b0, 1'b1);
      #3;
      if (n == 5) chk("midrst_edge5_gpio", 32'(gpio_o), 32'h00);
      if (n == 6) chk("midrst_edge6_gpio", 32'(gpio_o), 32'h01);
    end

    // Random bouncing, acknowledges and occasional resets.
    cur = 8'h01;
    for (int i = 0; i < 3000; i++) begin
      logic a;
      logic r;
      if ($urandom_range(0, 7) == 0) cur = cur ^ W'($urandom);
      a = ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 299) != 0);
      cycle(cur, a, r);
    end
    repeat (3) cycle(cur, 1'b0, 1'b1);

    repeat (2) @(posedge clk);
    #4 chk("sb_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_debounce.md
GPIO_DEBOUNCE -- requirements
Module: gpio_debounce

Interface
REQ-001 Parameter WIDTH, default 8: number of switch bits conditioned.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000: consecutive stable clk cycles required to accept a new level (10 ms at 50 MHz).
REQ-003 clk  input  1  system clock from the PLL; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 sw_i  input  WIDTH  raw board switch levels, asynchronous to clk.
REQ-006 ack_i  input  1  single-cycle strobe clearing the sticky change flags.
REQ-007 gpio_o  output  WIDTH  debounced switch levels, fed to the processor GPIO input.
REQ-008 changed_o  output  1  sticky flag: at least one gpio_o bit changed since the last ack.
REQ-009 rise_pend_o  output  WIDTH  sticky per-bit rising-edge pending mask.
REQ-010 fall_pend_o  output  WIDTH  sticky per-bit falling-edge pending mask.

Function
REQ-011 Each sw_i bit SHALL pass through a two-flop synchronizer before any other use.
REQ-012 Each bit SHALL have an FSM with states STABLE and COUNTING plus a counter of $clog2(DEBOUNCE_CYCLES) bits.
REQ-013 STABLE: a synchronized bit differing from gpio_o SHALL move the bit to COUNTING with the counter at 1.
REQ-014 COUNTING: each further mismatch cycle increments the counter; a match SHALL return the bit to STABLE with the counter at 0 (glitch rejected, gpio_o unchanged).
REQ-015 COUNTING: the mismatch cycle that brings the count to DEBOUNCE_CYCLES SHALL toggle gpio_o at that edge, clear the counter, and return the bit to STABLE.
REQ-016 Latency from a clean sw_i step to the gpio_o update SHALL be exactly 2 + DEBOUNCE_CYCLES clk edges.
REQ-017 The counter SHALL never wrap; it saturates at its terminal count by construction of REQ-015.
REQ-018 changed_o SHALL be set on the edge on which any gpio_o bit toggles.
REQ-019 ack_i SHALL clear changed_o and all pending masks on the next edge.
REQ-020 When a toggle and ack_i occur in the same cycle, set SHALL win: the new event remains flagged.
REQ-021 Bits SHALL be fully independent; simultaneous changes on several bits SHALL each follow REQ-013 to REQ-015.
REQ-022 An elaboration-time check SHALL reject DEBOUNCE_CYCLES < 2.

Reset
REQ-023 Asserting reset low SHALL immediately force the synchronizers, gpio_o, changed_o, rise_pend_o and fall_pend_o to 0, all counters to 0, and all FSMs to STABLE.
REQ-024 Reset asserted mid-count SHALL discard the count; after release a held-high switch SHALL reappear after the full 2 + DEBOUNCE_CYCLES latency.
REQ-025 Reset deassertion SHALL be synchronized externally; the block samples no input during reset.

Configuration
REQ-026 Macro GPIO_EDGE_PEND_EN defined: a toggle 0->1 SHALL set the bit's rise_pend_o, a toggle 1->0 SHALL set fall_pend_o, and both SHALL clear per REQ-019 and REQ-020.
REQ-027 Macro GPIO_EDGE_PEND_EN undefined: rise_pend_o and fall_pend_o SHALL be constant 0, the ports SHALL remain present, and no pending flops SHALL be generated.

Structure
REQ-028 A shared package gpio_pkg SHALL hold the FSM state enum (STABLE, COUNTING) and the default constants GPIO_WIDTH_DEF=8 and DEBOUNCE_CYCLES_DEF=500000.
REQ-029 A sub-module debounce_bit (synchronizer, FSM, counter for one bit) SHALL be instantiated WIDTH times by a generate loop.
REQ-030 gpio_debounce SHALL hold only the flag/pending logic and the instance array.

Verification (bench uses WIDTH=8, DEBOUNCE_CYCLES=4)
REQ-031 Reset low, sw_i=0xFF, then reset high held -> gpio_o=0x00 during reset; gpio_o=0xFF exactly 6 edges after release; changed_o=1.
REQ-032 sw_i bit0 pulses high for 3 cycles and back low -> gpio_o stays 0x00; changed_o stays 0.
REQ-033 sw_i 0x00->0x81 held -> gpio_o=0x81 at edge 6; with the macro defined, rise_pend_o=0x81 and fall_pend_o=0x00; ack_i pulse -> all flags 0.
REQ-034 ack_i asserted on the same edge on which gpio_o bit3 toggles -> changed_o remains 1 after that edge.
REQ-035 Reset asserted after 2 counting cycles with sw_i=0x01 held -> counter cleared; gpio_o=0x01 at 6 edges after release.
REQ-036 Build without GPIO_EDGE_PEND_EN, toggle 0x00->0xFF->0x00 -> rise_pend_o and fall_pend_o stay 0x00 throughout.
